// File: rtl/framebuffer_writer_if.sv
// rtl/framebuffer_writer_if.sv - pixel stream and framebuffer write-port bundle
// Purpose: groups the rasterizer pixel stream and the memory write port.
// Signals:
//   in_x, in_y, in_color, in_draw, in_valid -> pixel stream from rasterizer
//   in_ready                                <- pixel stream ready
//   mem_addr, mem_data, mem_we              <- framebuffer write request
//   mem_ready                               -> memory accepts write this cycle
// Modports: slave = the writer block, master = the surrounding system.
interface framebuffer_writer_if #(
    parameter int ADDR_W = 20
);
    logic [10:0]       in_x;
    logic [10:0]       in_y;
    logic [7:0]        in_color;
    logic              in_draw;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_data;
    logic              mem_we;
    logic              mem_ready;

    modport slave (
        input  in_x, in_y, in_color, in_draw, in_valid,
        output in_ready,
        output mem_addr, mem_data, mem_we,
        input  mem_ready
    );

    modport master (
        output in_x, in_y, in_color, in_draw, in_valid,
        input  in_ready,
        input  mem_addr, mem_data, mem_we,
        output mem_ready
    );
endinterface

// File: rtl/framebuffer_writer.sv
// rtl/framebuffer_writer.sv - filters pixels, computes addresses, buffers and drains framebuffer writes
// Purpose: consumes the rasterizer pixel stream, drops undrawn and off-screen
// pixels, converts (x,y) into a linear 8bpp framebuffer address, queues writes
// in a first-word-fall-through FIFO and drains them to the memory write port.
// Tracks frames from frame_end and pulses frame_done once a frame has left.
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   bus            pixel stream in / memory write port out (slave modport)
//   frame_end      high while rasterizer idle, low during a frame
//   fb_base        framebuffer base, latched at frame start
//   pixel_count    writes issued to memory this frame (saturating)
//   drop_count     off-screen draw pixels this frame (saturating)
//   busy           frame in progress
//   frame_done     one-cycle pulse when a frame is fully written
module framebuffer_writer #(
    parameter int H_RES      = 800,
    parameter int V_RES      = 600,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 20
) (
    input  logic                clk,
    input  logic                reset,
    framebuffer_writer_if.slave bus,
    input  logic                frame_end,
    input  logic [ADDR_W-1:0]   fb_base,
    output logic [19:0]         pixel_count,
    output logic [15:0]         drop_count,
    output logic                busy,
    output logic                frame_done
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [10:0] H_LIM = 11'(H_RES);
    localparam logic [10:0] V_LIM = 11'(V_RES);

    typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN, DONE} state_t;

    state_t state, state_next;
    logic   frame_start;

    logic                  stage_valid;
    logic [ADDR_W-1:0]     stage_addr;
    logic [7:0]            stage_color;
    logic [ADDR_W-1:0]     base_lat;

    logic [ADDR_W+7:0]     fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      fifo_count;
    logic [CNT_W-1:0]      occupancy;

    logic                  xfer, in_range, load, drop, push, pop, in_frame;
    logic                  fifo_drains;
    logic [ADDR_W-1:0]     y_ext, y_mul, pix_addr;

    // The address stage holds a slot reserved in the FIFO, so counting it
    // here guarantees an accepted pixel always finds room one cycle later.
    assign occupancy    = fifo_count + CNT_W'(stage_valid);
    assign bus.in_ready = occupancy < CNT_W'(FIFO_DEPTH);

    assign xfer     = bus.in_valid && bus.in_ready;
    assign in_range = (bus.in_x < H_LIM) && (bus.in_y < V_LIM);
    assign load     = xfer && bus.in_draw && in_range;
    assign drop     = xfer && bus.in_draw && !in_range;

    // y*800 as shift-add so no multiplier is inferred at the default width.
    assign y_ext    = ADDR_W'(bus.in_y);
    assign y_mul    = (H_RES == 800) ? ((y_ext << 9) + (y_ext << 8) + (y_ext << 5))
                                     : (y_ext * ADDR_W'(H_RES));
    assign pix_addr = base_lat + y_mul + ADDR_W'(bus.in_x);

    assign push = stage_valid;
    assign bus.mem_we = (fifo_count != '0);
    assign pop  = bus.mem_we && bus.mem_ready;

    // Head is forced to zero when empty so the port idles at a known value.
    assign bus.mem_addr = bus.mem_we ? fifo_mem[rd_ptr][ADDR_W+7:8] : '0;
    assign bus.mem_data = bus.mem_we ? fifo_mem[rd_ptr][7:0]        : '0;

    // FIFO will be empty after this cycle's pop completes.
    assign fifo_drains = (fifo_count == '0) || ((fifo_count == CNT_W'(1)) && pop);

    // Stray pixels in IDLE are written but belong to no frame's counts.
    assign in_frame = (state != IDLE);

    always_comb begin
        state_next  = state;
        frame_start = 1'b0;
        case (state)
            IDLE: begin
                if (!frame_end) begin
                    state_next  = ACTIVE;
                    frame_start = 1'b1;
                end
            end
            ACTIVE: begin
                if (frame_end) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!stage_valid && !xfer && fifo_drains) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy       = (state != IDLE);
    assign frame_done = (state == DONE);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {stage_addr, stage_color};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            stage_valid <= 1'b0;
            stage_addr  <= '0;
            stage_color <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            base_lat    <= '0;
            pixel_count <= '0;
            drop_count  <= '0;
        end else begin
            state       <= state_next;
            stage_valid <= load;
            if (load) begin
                stage_addr  <= pix_addr;
                stage_color <= bus.in_color;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                fifo_count <= fifo_count + CNT_W'(1);
            end else if (!push && pop) begin
                fifo_count <= fifo_count - CNT_W'(1);
            end
            if (frame_start) begin
                base_lat    <= fb_base;
                pixel_count <= '0;
                drop_count  <= '0;
            end else begin
                if (pop && in_frame && (pixel_count != '1)) begin
                    pixel_count <= pixel_count + 20'd1;
                end
                if (drop && in_frame && (drop_count != '1)) begin
                    drop_count <= drop_count + 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_framebuffer_writer.sv
// tb/tb_framebuffer_writer.sv - self-checking bench for framebuffer_writer
module tb_framebuffer_writer;
    localparam int ADDR_W = 20;

    typedef struct packed {
        logic [19:0] addr;
        logic [7:0]  data;
    } wr_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        frame_end;
    logic [19:0] fb_base;
    logic [19:0] pixel_count;
    logic [15:0] drop_count;
    logic        busy;
    logic        frame_done;

    framebuffer_writer_if #(.ADDR_W(ADDR_W)) bus ();

    framebuffer_writer #(
        .H_RES(800), .V_RES(600), .FIFO_DEPTH(16), .ADDR_W(ADDR_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .frame_end(frame_end),
        .fb_base(fb_base),
        .pixel_count(pixel_count),
        .drop_count(drop_count),
        .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_writes = 0;
    int last_pop_cyc = 0;
    int done_count = 0;
    int done_cyc = 0;
    logic [19:0] last_addr = '0;
    logic [19:0] exp_base = '0;
    wr_t exp_q[$];
    wr_t mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expected writes are pushed on accepted handshakes and
    // popped/compared when the memory port completes a write.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            if (bus.mem_we && bus.mem_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL write_unexpected addr=%0d data=%h", bus.mem_addr, bus.mem_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (bus.mem_addr !== mon_e.addr || bus.mem_data !== mon_e.data) begin
                        errors++;
                        $display("FAIL write_order got addr=%0d data=%h expected addr=%0d data=%h",
                                 bus.mem_addr, bus.mem_data, mon_e.addr, mon_e.data);
                    end
                end
                n_writes++;
                last_pop_cyc = cyc;
                last_addr = bus.mem_addr;
            end
            if (bus.in_valid && bus.in_ready && bus.in_draw &&
                bus.in_x < 11'd800 && bus.in_y < 11'd600) begin
                exp_q.push_back({exp_base + 20'(bus.in_y) * 20'd800 + 20'(bus.in_x), bus.in_color});
            end
            if (frame_done) begin
                done_count++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.in_valid = 1'b0;
        bus.in_draw  = 1'b0;
        bus.in_x     = '0;
        bus.in_y     = '0;
        bus.in_color = '0;
    endtask

    task automatic set_pixel(input int x, input int y, input int c, input bit d);
        bus.in_x     = 11'(x);
        bus.in_y     = 11'(y);
        bus.in_color = 8'(c);
        bus.in_draw  = d;
        bus.in_valid = 1'b1;
    endtask

    task automatic send_pixel(input int x, input int y, input int c, input bit d);
        bit ok = 1'b0;
        set_pixel(x, y, c, d);
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            ok = bus.in_ready;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL send_timeout pixel (%0d,%0d) not accepted within 50 cycles", x, y);
        end
    endtask

    task automatic start_frame(input logic [19:0] base);
        idle_inputs();
        fb_base   = base;
        exp_base  = base;
        frame_end = 1'b0;
        tick();
    endtask

    task automatic end_frame_wait(input string name);
        int d0 = done_count;
        frame_end = 1'b1;
        for (int i = 0; i < 100 && done_count == d0; i++) tick();
        checks++;
        if (done_count != d0 + 1) begin
            errors++;
            $display("FAIL %s_frame_done pulses=%0d expected 1", name, done_count - d0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        frame_end = 1'b1;
        fb_base = '0;
        bus.mem_ready = 1'b0;
        idle_inputs();
        repeat (3) tick();
        reset = 1'b0;
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b expected 0", bus.mem_we); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", bus.in_ready); end
        checks++; if (bus.mem_addr !== 20'd0) begin errors++; $display("FAIL reset_mem_addr got %0d expected 0", bus.mem_addr); end
        checks++; if (pixel_count !== 20'd0) begin errors++; $display("FAIL reset_pixel_count got %0d expected 0", pixel_count); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL reset_drop_count got %0d expected 0", drop_count); end
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL reset_busy_done got %b%b expected 00", busy, frame_done); end
    endtask

    task automatic test_single_pixel();
        bus.mem_ready = 1'b1;
        start_frame(20'd0);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b expected 1", busy); end
        send_pixel(3, 2, 8'h55, 1'b1);
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL single_latency_early mem_we got %b expected 0", bus.mem_we); end
        tick();
        checks++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 20'd1603 || bus.mem_data !== 8'h55) begin
            errors++;
            $display("FAIL single_write got we=%b addr=%0d data=%h expected we=1 addr=1603 data=55",
                     bus.mem_we, bus.mem_addr, bus.mem_data);
        end
        tick();
        checks++; if (pixel_count !== 20'd1) begin errors++; $display("FAIL single_pixel_count got %0d expected 1", pixel_count); end
        end_frame_wait("single");
        tick();
        checks++; if (pixel_count !== 20'd1) begin errors++; $display("FAIL single_count_hold got %0d expected 1", pixel_count); end
    endtask

    task automatic test_filter();
        int w0;
        bus.mem_ready = 1'b1;
        start_frame(20'd0);
        w0 = n_writes;
        send_pixel(10, 10, 8'h11, 1'b0);
        send_pixel(800, 0, 8'h22, 1'b1);
        send_pixel(0, 600, 8'h33, 1'b1);
        send_pixel(799, 599, 8'h44, 1'b1);
        repeat (5) tick();
        checks++; if (n_writes - w0 != 1) begin errors++; $display("FAIL filter_writes got %0d expected 1", n_writes - w0); end
        checks++; if (last_addr !== 20'd479999) begin errors++; $display("FAIL filter_addr got %0d expected 479999", last_addr); end
        checks++; if (drop_count !== 16'd2) begin errors++; $display("FAIL filter_drop_count got %0d expected 2", drop_count); end
        checks++; if (pixel_count !== 20'd1) begin errors++; $display("FAIL filter_pixel_count got %0d expected 1", pixel_count); end
        end_frame_wait("filter");
    endtask

    task automatic test_back_to_back();
        int c0, w0;
        bus.mem_ready = 1'b1;
        start_frame(20'h00100);
        c0 = cyc;
        w0 = n_writes;
        for (int i = 0; i < 8; i++) send_pixel(i, 5, i + 8'h60, 1'b1);
        checks++; if (cyc - c0 != 8) begin errors++; $display("FAIL b2b_accept_cycles got %0d expected 8", cyc - c0); end
        repeat (4) tick();
        checks++; if (n_writes - w0 != 8) begin errors++; $display("FAIL b2b_writes got %0d expected 8", n_writes - w0); end
        end_frame_wait("b2b");
    endtask

    task automatic test_backpressure();
        int idx = 0;
        int w0;
        bit have_head = 1'b0;
        bit stable = 1'b1;
        logic [19:0] head_addr = '0;
        logic [7:0]  head_data = '0;
        bus.mem_ready = 1'b0;
        start_frame(20'h02000);
        w0 = n_writes;
        for (int c = 0; c < 40; c++) begin
            if (idx < 20) set_pixel(idx * 7, 3, idx + 8'h10, 1'b1);
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            if (bus.mem_we) begin
                if (!have_head) begin
                    have_head = 1'b1;
                    head_addr = bus.mem_addr;
                    head_data = bus.mem_data;
                end else if (bus.mem_addr !== head_addr || bus.mem_data !== head_data) begin
                    stable = 1'b0;
                end
            end
            tick();
        end
        checks++; if (idx != 16) begin errors++; $display("FAIL bp_accepted got %0d expected 16", idx); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b expected 0", bus.in_ready); end
        checks++; if (!stable || !have_head) begin errors++; $display("FAIL bp_head_stable got stable=%0d seen=%0d expected 1 1", stable, have_head); end
        bus.mem_ready = 1'b1;
        for (int c = 0; c < 60 && !(idx == 20 && exp_q.size() == 0); c++) begin
            if (idx < 20) set_pixel(idx * 7, 3, idx + 8'h10, 1'b1);
            else bus.in_valid = 1'b0;
            @(negedge clk);
            if (bus.in_valid && bus.in_ready) idx++;
            tick();
        end
        bus.in_valid = 1'b0;
        checks++; if (idx != 20) begin errors++; $display("FAIL bp_total_accepted got %0d expected 20", idx); end
        checks++; if (n_writes - w0 != 20) begin errors++; $display("FAIL bp_writes got %0d expected 20", n_writes - w0); end
        checks++; if (pixel_count !== 20'd20) begin errors++; $display("FAIL bp_pixel_count got %0d expected 20", pixel_count); end
        end_frame_wait("bp");
    endtask

    task automatic test_frame_done();
        int d0, p0;
        bus.mem_ready = 1'b0;
        start_frame(20'd0);
        for (int i = 0; i < 5; i++) send_pixel(100 + i, 7, 8'hA0 + i, 1'b1);
        frame_end = 1'b1;
        repeat (2) tick();
        d0 = done_count;
        p0 = n_writes;
        for (int i = 0; i < 40 && frame_done !== 1'b1; i++) begin
            bus.mem_ready = !bus.mem_ready;
            tick();
        end
        bus.mem_ready = 1'b0;
        checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL fd_timeout frame_done got %b expected 1", frame_done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL fd_busy_during got %b expected 1", busy); end
        tick();
        checks++; if (busy !== 1'b0 || frame_done !== 1'b0) begin errors++; $display("FAIL fd_after got busy=%b done=%b expected 0 0", busy, frame_done); end
        repeat (5) tick();
        checks++; if (done_count - d0 != 1) begin errors++; $display("FAIL fd_pulses got %0d expected 1", done_count - d0); end
        checks++; if (n_writes - p0 != 5) begin errors++; $display("FAIL fd_writes got %0d expected 5", n_writes - p0); end
        checks++; if (done_cyc != last_pop_cyc + 1) begin errors++; $display("FAIL fd_timing got %0d cycles after last pop expected 1", done_cyc - last_pop_cyc); end
    endtask

    task automatic test_base_latch();
        bus.mem_ready = 1'b1;
        start_frame(20'h80000);
        fb_base = 20'd0;
        tick();
        send_pixel(1, 0, 8'hAA, 1'b1);
        repeat (3) tick();
        checks++; if (last_addr !== 20'h80001) begin errors++; $display("FAIL base_latch got %h expected 80001", last_addr); end
        end_frame_wait("base");
    endtask

    task automatic test_reset_mid();
        int d0;
        bus.mem_ready = 1'b0;
        start_frame(20'd0);
        send_pixel(900, 0, 8'h01, 1'b1);
        for (int i = 0; i < 30 && bus.in_ready; i++) begin
            set_pixel(i, 0, i, 1'b1);
            tick();
        end
        idle_inputs();
        checks++; if (bus.in_ready !== 1'b0 || drop_count !== 16'd1) begin errors++; $display("FAIL rm_prefill got ready=%b drops=%0d expected 0 1", bus.in_ready, drop_count); end
        frame_end = 1'b1;
        d0 = done_count;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (bus.mem_we !== 1'b0) begin errors++; $display("FAIL rm_mem_we got %b expected 0", bus.mem_we); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rm_in_ready got %b expected 1", bus.in_ready); end
        checks++; if (pixel_count !== 20'd0 || drop_count !== 16'd0) begin errors++; $display("FAIL rm_counts got %0d %0d expected 0 0", pixel_count, drop_count); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_state got busy=%b expected 0", busy); end
        repeat (10) tick();
        checks++; if (done_count != d0) begin errors++; $display("FAIL rm_no_done got %0d pulses expected 0", done_count - d0); end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_pixel();
        test_filter();
        test_back_to_back();
        test_backpressure();
        test_frame_done();
        test_base_latch();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
